// File: rtl/mastermind_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mastermind_round_ctrl
// Brief   : Scores one 4-peg Mastermind guess, holds the result, then advances
//           the row counter or ends the game.
// Revision: 1.0 - initial release
// ============================================================================
module mastermind_round_ctrl #(
  parameter int unsigned START_ROW   = 7,
  parameter int unsigned NUM_COLOURS = 6,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iSubmit,
  input  logic [2:0] iGuess0,
  input  logic [2:0] iGuess1,
  input  logic [2:0] iGuess2,
  input  logic [2:0] iGuess3,
  input  logic [2:0] iSolution0,
  input  logic [2:0] iSolution1,
  input  logic [2:0] iSolution2,
  input  logic [2:0] iSolution3,
  output logic       oReady,
  output logic       oBusy,
  output logic [2:0] oBlackPegs,
  output logic [2:0] oWhitePegs,
  output logic       oResultValid,
  output logic       oClearGuess,
  output logic [2:0] oRow,
  output logic       oWin,
  output logic       oLose
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [2:0] LAST_COLOUR = 3'(NUM_COLOURS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BLACK   = 3'd1,
    S_WHITE   = 3'd2,
    S_SUM     = 3'd3,
    S_HOLD    = 3'd4,
    S_ADVANCE = 3'd5,
    S_WON     = 3'd6,
    S_LOST    = 3'd7
  } state_t;

  state_t            state_q;
  logic [3:0][2:0]   guess_q;
  logic [3:0][2:0]   sol_q;
  logic [2:0]        black_q;
  logic [2:0]        total_q;
  logic [2:0]        step_q;
  logic [HOLD_W-1:0] hold_q;
  logic [2:0]        row_q;
  logic [2:0]        black_pegs_q;
  logic [2:0]        white_pegs_q;
  logic              result_valid_q;
  logic              clear_guess_q;

  logic [3:0][2:0]   guess_in;
  logic [3:0][2:0]   sol_in;
  logic              accept;
  logic [2:0]        guess_cnt;
  logic [2:0]        sol_cnt;
  logic [2:0]        black_d;
  logic [2:0]        total_d;

  function automatic logic [2:0] count_colour(input logic [3:0][2:0] pegs,
                                              input logic [2:0]      colour);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n = n + {2'b00, pegs[k] == colour};
    end
    return n;
  endfunction

  assign guess_in = {iGuess3, iGuess2, iGuess1, iGuess0};
  assign sol_in   = {iSolution3, iSolution2, iSolution1, iSolution0};
  assign accept   = iSubmit && (iGuess0 != 3'd0) && (iGuess1 != 3'd0) &&
                    (iGuess2 != 3'd0) && (iGuess3 != 3'd0);

  // In BLACK step_q is the column index; in WHITE it is the colour under test.
  assign black_d   = black_q + {2'b00, guess_q[step_q[1:0]] == sol_q[step_q[1:0]]};
  assign guess_cnt = count_colour(guess_q, step_q);
  assign sol_cnt   = count_colour(sol_q, step_q);
  assign total_d   = total_q + ((guess_cnt < sol_cnt) ? guess_cnt : sol_cnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      guess_q        <= '0;
      sol_q          <= '0;
      black_q        <= 3'd0;
      total_q        <= 3'd0;
      step_q         <= 3'd0;
      hold_q         <= '0;
      row_q          <= 3'(START_ROW);
      black_pegs_q   <= 3'd0;
      white_pegs_q   <= 3'd0;
      result_valid_q <= 1'b0;
      clear_guess_q  <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      clear_guess_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            guess_q      <= guess_in;
            sol_q        <= sol_in;
            black_q      <= 3'd0;
            total_q      <= 3'd0;
            step_q       <= 3'd0;
            black_pegs_q <= 3'd0;
            white_pegs_q <= 3'd0;
            state_q      <= S_BLACK;
          end
        end
        S_BLACK: begin
          black_q <= black_d;
          if (step_q == 3'd3) begin
            step_q  <= 3'd1;
            state_q <= S_WHITE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        S_WHITE: begin
          total_q <= total_d;
          if (step_q == LAST_COLOUR) begin
            state_q <= S_SUM;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        S_SUM: begin
          black_pegs_q   <= black_q;
          white_pegs_q   <= total_q - black_q;
          result_valid_q <= 1'b1;
          hold_q         <= '0;
          state_q        <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= S_ADVANCE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        S_ADVANCE: begin
          if (black_q == 3'd4) begin
            state_q <= S_WON;
          end else if (row_q == 3'd0) begin
            state_q <= S_LOST;
          end else begin
            row_q         <= row_q - 3'd1;
            clear_guess_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        S_WON:   state_q <= S_WON;
        S_LOST:  state_q <= S_LOST;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oReady       = (state_q == S_IDLE);
  assign oBusy        = (state_q == S_BLACK) || (state_q == S_WHITE) ||
                        (state_q == S_SUM)   || (state_q == S_HOLD);
  assign oWin         = (state_q == S_WON);
  assign oLose        = (state_q == S_LOST);
  assign oBlackPegs   = black_pegs_q;
  assign oWhitePegs   = white_pegs_q;
  assign oResultValid = result_valid_q;
  assign oClearGuess  = clear_guess_q;
  assign oRow         = row_q;

endmodule
`default_nettype wire

// File: doc/mastermind_round_ctrl.md
Name: mastermind_round_ctrl

Overview:
- Sequencing controller for one Mastermind round: accepts a submitted 4-peg guess, scores it against the secret code and publishes the black/white peg counts.
- Holds the result for a display interval, then advances the active row or ends the game (win/lose).
- Sits between the touch-input block (guess entry, row selection) and the display/LED logic.
- Owns the row counter; the touch-input block follows oRow and clears its guess on oClearGuess.

Parameters:
START_ROW, 7, row index at reset; rows count down to 0 (8 attempts).
NUM_COLOURS, 6, peg colours are 1..NUM_COLOURS; 0 means empty.
HOLD_CYCLES, 25000000, clock cycles the result is held before advancing (0.5 s at 50 MHz).

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; low forces the reset state immediately
iSubmit  input  1  guess-submit request, level sampled each cycle
iGuess0..iGuess3  input  3 each  guess colour per column, 0 = empty
iSolution0..iSolution3  input  3 each  secret code, values 1..NUM_COLOURS
oReady  output  1  high only in IDLE: a submit can be accepted
oBusy  output  1  high in BLACK, WHITE, SUM and HOLD
oBlackPegs  output  3  right colour, right position (0..4)
oWhitePegs  output  3  right colour, wrong position (0..4)
oResultValid  output  1  one-cycle pulse when peg outputs update
oClearGuess  output  1  one-cycle pulse: the touch-input block clears its column values
oRow  output  3  active row index
oWin  output  1  high in WON
oLose  output  1  high in LOST

Behaviour:
- Reset (asynchronous, reset low): state=IDLE, oRow=START_ROW, oBlackPegs=0, oWhitePegs=0. oResultValid, oClearGuess, oWin and oLose are all 0. Internal counters are 0. Reset asserted in any state aborts the operation with no partial output.
- States: IDLE, BLACK, WHITE, SUM, HOLD, ADVANCE, WON, LOST.
- IDLE: a submit is accepted when iSubmit=1 and all four iGuess values are non-zero. On acceptance:
  - latch the guesses and solution into internal registers;
  - clear oBlackPegs and oWhitePegs to 0 and reset the accumulators;
  - go to BLACK.
  A submit with any iGuess=0 is ignored, and the state stays IDLE.
- iSubmit is ignored in every state other than IDLE. There is no queueing.
- BLACK: 4 cycles, index i=0..3. Each cycle, black += (guess[i]==sol[i]).
- WHITE: NUM_COLOURS cycles, colour c=1..NUM_COLOURS. Each cycle:
  - count occurrences of c in the latched guess (0..4) and in the latched solution (0..4);
  - total += min(guess count, solution count).
- SUM: 1 cycle. oBlackPegs=black and oWhitePegs=total-black, both registered. Assert oResultValid for exactly this one registered cycle, then go to HOLD.
- Latency: with the accept edge as cycle 0, oResultValid is high during cycle 4+NUM_COLOURS+1 (cycle 11 at default).
- Width rules: total ≤ 4 and black ≤ total always; the subtraction never underflows. The accumulators are 3 bits.
- HOLD: count HOLD_CYCLES cycles, then go to ADVANCE. Peg outputs are stable throughout.
- ADVANCE: 1 cycle, with priority:
  1. black==4 → WON;
  2. else oRow==0 → LOST;
  3. else oRow-=1, pulse oClearGuess for 1 cycle, go to IDLE.
- WON/LOST are terminal until reset. oWin or oLose stays high, and the peg outputs keep the final result.
- Peg outputs persist in IDLE until the next accepted submit.
- Changes on iSolution after acceptance have no effect on the current scoring.
- oRow never wraps below 0.

Test Plan:
- Exact match: sol 1,2,3,4, guess 1,2,3,4 → black=4, white=0; oResultValid exactly 11 cycles after accept; oWin=1 after HOLD+1; oRow stays 7.
- Full permutation: sol 1,2,3,4, guess 4,3,2,1 → black=0, white=4. After HOLD: oRow=6, oClearGuess pulses once, oReady=1.
- Duplicates: sol 1,1,2,2, guess 1,2,1,3 → black=1, white=2. Also sol 5,5,5,5, guess 5,1,1,1 → black=1, white=0.
- Input gating:
  - submit with guess 3,0,2,1 → ignored, oReady stays 1;
  - submit pulses during BLACK/HOLD → ignored;
  - changing iSolution mid-scoring → result unchanged.
- Exhaustion: 8 consecutive non-winning guesses → oRow steps 7→0; after the 8th result oLose=1 and oRow=0. Further submits are ignored until reset.
- Async reset: assert reset low mid-WHITE, between clock edges → outputs go to reset values immediately (oRow=7, pegs 0, oReady=1 after release). Bench uses HOLD_CYCLES=4.
